// File: rtl/inst_fetch.sv
// Instruction-fetch requester: drives the synchronous instruction RAM read
// port, buffers returned words in a 2-entry FIFO and hands PC/instruction
// pairs to decode over a valid/ready handshake. A branch redirect kills
// both the in-flight response and everything already buffered.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ram_ce_o,
  output logic [31:0] ram_raddr_o,
  output logic        ram_flush_o,
  input  logic [31:0] ram_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;

  // Target is word aligned; the low two bits carry no meaning here.
  logic        unused_tgt;
  assign unused_tgt = ^branch_target_i[1:0];

  // Credit check: buffered + in-flight words after this cycle's pop must
  // leave room for one more response, so the FIFO can never overflow.
  always_comb begin
    occ          = 3'd0;
    inst_valid_o = (count != 2'd0) & ~branch_flag_i;
    pop          = inst_valid_o & inst_ready_i;
    push         = pend & ~branch_flag_i;
    occ          = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    issue        = reset & ~branch_flag_i & (occ < 3'd2);
  end

  assign ram_ce_o    = issue;
  assign ram_raddr_o = pc;
  assign ram_flush_o = branch_flag_i;
  assign inst_o      = fifo_inst[rd_ptr];
  assign inst_pc_o   = fifo_pc[rd_ptr];

  // PC, pending-response tracking and FIFO bookkeeping; branch flushes all.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 32'h0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_inst[i] <= 32'h0;
        fifo_pc[i]   <= 32'h0;
      end
    end else if (branch_flag_i) begin
      pc     <= {branch_target_i[31:2], 2'b00};
      pend   <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (issue) begin
        pc      <= pc + 32'd4;
        pend    <= 1'b1;
        pend_pc <= pc;
      end else begin
        pend <= 1'b0;
      end
      if (push) begin
        fifo_inst[wr_ptr] <= ram_rdata_i;
        fifo_pc[wr_ptr]   <= pend_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural one-cycle-latency RAM.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        ram_ce_o;
  logic [31:0] ram_raddr_o;
  logic        ram_flush_o;
  logic [31:0] ram_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc = RST_PC;

  inst_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .ram_ce_o       (ram_ce_o),
    .ram_raddr_o    (ram_raddr_o),
    .ram_flush_o    (ram_flush_o),
    .ram_rdata_i    (ram_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ramf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous RAM: word appears the cycle after the read; flush zeroes it.
  always @(posedge clock) begin
    if (ram_flush_o)   ram_rdata_i <= 32'h0;
    else if (ram_ce_o) ram_rdata_i <= ramf(ram_raddr_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A response arriving while the FIFO holds two words would be lost.
  always @(negedge clock) begin
    if (reset && !branch_flag_i) begin
      n_chk++;
      assert (!(dut.pend && dut.count == 2'd2))
      else begin
        n_fail++;
        $error("FAIL push_full: observed pend=%0b count=%0d expected no push when full",
               dut.pend, dut.count);
      end
    end
  end

  // One cycle: drive inputs just after the edge, then score any handshake.
  task automatic step(input logic rst, input logic rdy, input logic br, input logic [31:0] tgt);
    @(posedge clock);
    #1;
    reset = rst; inst_ready_i = rdy; branch_flag_i = br; branch_target_i = tgt;
    #1;
    if (!rst) exp_pc = RST_PC;
    else if (br) exp_pc = {tgt[31:2], 2'b00};
    if (inst_valid_o && inst_ready_i) begin
      chk("deliver_pc", inst_pc_o, exp_pc);
      chk("deliver_inst", inst_o, ramf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles; branch asserted during reset must lose.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_ce", {31'h0, ram_ce_o}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_addr", ram_raddr_o, RST_PC);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0800);
    chk("rst_flush", {31'h0, ram_flush_o}, 32'h1);
    chk("rst_br_ce", {31'h0, ram_ce_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Startup.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_ce", {31'h0, ram_ce_o}, 32'h1);
    chk("start_addr", ram_raddr_o, RST_PC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_valid0", {31'h0, inst_valid_o}, 32'h0);
    chk("start_addr1", ram_raddr_o, RST_PC + 32'd4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_valid1", {31'h0, inst_valid_o}, 32'h1);
    chk("start_pc0", inst_pc_o, RST_PC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_pc1", inst_pc_o, RST_PC + 32'd4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_pc2", inst_pc_o, RST_PC + 32'd8);
    for (int i = 0; i < 10 && n_deliv < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("deliv4", n_deliv, 4);

    // Back-pressure stall for five cycles.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_ce", {31'h0, ram_ce_o}, 32'h0);
      chk("stall_valid", {31'h0, inst_valid_o}, 32'h1);
    end
    chk("stall_count", {30'h0, dut.count}, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("resume_deliv", n_deliv, 8);

    // Redirect with two words buffered.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h1c00_0102);
    chk("br1_flush", {31'h0, ram_flush_o}, 32'h1);
    chk("br1_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("br1_ce", {31'h0, ram_ce_o}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("br1_ce1", {31'h0, ram_ce_o}, 32'h1);
    chk("br1_addr", ram_raddr_o, 32'h1c00_0100);
    chk("br1_valid1", {31'h0, inst_valid_o}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("br1_valid2", {31'h0, inst_valid_o}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("br1_valid3", {31'h0, inst_valid_o}, 32'h1);
    chk("br1_pc", inst_pc_o, 32'h1c00_0100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect during a full stall.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_count", {30'h0, dut.count}, 32'd2);
    step(1'b1, 1'b0, 1'b1, 32'h1c00_0400);
    chk("br2_flush", {31'h0, ram_flush_o}, 32'h1);
    chk("br2_valid", {31'h0, inst_valid_o}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("br2_addr", ram_raddr_o, 32'h1c00_0400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("br2_addr1", ram_raddr_o, 32'h1c00_0404);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("br2_valid3", {31'h0, inst_valid_o}, 32'h1);
    chk("br2_pc", inst_pc_o, 32'h1c00_0400);
    chk("br2_ce3", {31'h0, ram_ce_o}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("br2_first", inst_pc_o, 32'h1c00_0400);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset asserted mid-stream with one buffered and one pending.
    chk("mid_pend", {31'h0, dut.pend}, 32'h1);
    chk("mid_count", {30'h0, dut.count}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("mid_ce", {31'h0, ram_ce_o}, 32'h0);
    chk("mid_addr", ram_raddr_o, RST_PC);
    chk("mid_inst_pc", inst_pc_o, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_addr", ram_raddr_o, RST_PC);
    chk("restart_ce", {31'h0, ram_ce_o}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_pc", inst_pc_o, RST_PC);

    // Wrap past the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr0", ram_raddr_o, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", ram_raddr_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr2", ram_raddr_o, 32'h0000_0000);
    chk("wrap_pc0", inst_pc_o, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc1", inst_pc_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc2", inst_pc_o, 32'h0000_0000);
    chk("wrap_inst2", inst_o, ramf(32'h0));
    step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
